// File: rtl/sseg_scan_mux_pkg.sv
// ---------------------------------------------------------------------------
// sseg_pkg
// Shared seven-segment definitions used by the scan multiplexer and by the
// display-formatting blocks that feed it.
//   SEG_BLANK_N   : all segments (and DP) off, active-low encoding
//   seg_t         : one digit's segment pattern, bit 7 = DP, bits 6..0 = g..a
//   hex_to_seg_n  : nibble to active-low segment pattern, DP left off
// ---------------------------------------------------------------------------
package sseg_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK_N = 8'hFF;

    function automatic seg_t hex_to_seg_n(input logic [3:0] nibble);
        seg_t seg;
        case (nibble)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sseg_scan_mux_if.sv
// ---------------------------------------------------------------------------
// sseg_scan_mux_if
// Bundle between the display-formatting logic and the scan multiplexer.
//   i_seg_n    : per-digit segment patterns, active-low, bit 7 = DP
//   i_digit_en : per-digit enable, 1 = digit may light
//   i_bright   : brightness level, 0 = off
//   o_an       : one-hot anode select, active-high
//   o_sseg_n   : segment drive, active-low
//   o_frame    : one-cycle pulse when the digit index wraps to 0
// master = formatter side, slave = multiplexer side.
// ---------------------------------------------------------------------------
interface sseg_scan_mux_if #(
    parameter int NUM_DIGITS = 8,
    parameter int DUTY_BITS  = 4
);
    logic [NUM_DIGITS-1:0][7:0] i_seg_n;
    logic [NUM_DIGITS-1:0]      i_digit_en;
    logic [DUTY_BITS-1:0]       i_bright;
    logic [NUM_DIGITS-1:0]      o_an;
    logic [7:0]                 o_sseg_n;
    logic                       o_frame;

    modport master (
        output i_seg_n,
        output i_digit_en,
        output i_bright,
        input  o_an,
        input  o_sseg_n,
        input  o_frame
    );

    modport slave (
        input  i_seg_n,
        input  i_digit_en,
        input  i_bright,
        output o_an,
        output o_sseg_n,
        output o_frame
    );
endinterface

// File: rtl/sseg_scan_mux_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Modulo-DIV counter producing a one-cycle clock-enable pulse every DIV
// cycles. Used wherever a slow timebase is needed without a derived clock.
//   i_clk   : system clock
//   i_reset : synchronous, active-high; counter restarts at 0
//   o_tick  : high in the cycle the counter equals DIV-1
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 3125
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    always_comb begin
        wrap  = (cnt_q == CNT_W'(DIV - 1));
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = wrap;

endmodule

// File: rtl/sseg_scan_mux.sv
// ---------------------------------------------------------------------------
// sseg_scan_mux
// N-digit seven-segment scan multiplexer with per-digit enable and PWM
// brightness. Each digit owns a slot of 2^DUTY_BITS phases; a phase lasts
// TICK_DIV clocks. Phase 0 of every slot is forced dark so the previous
// digit's pattern never ghosts onto the next anode.
//   i_clk   : system clock (only clock, counters advance on a tick enable)
//   i_reset : synchronous, active-high
//   bus     : slave side of sseg_scan_mux_if (patterns, enables, brightness
//             in; registered anode/segment drive and frame pulse out)
// ---------------------------------------------------------------------------
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 3125,
    parameter int DUTY_BITS  = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    sseg_scan_mux_if.slave  bus
);
    localparam int DIG_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] AN_LSB     = NUM_DIGITS'(1);
    localparam logic [DIG_W-1:0]      DIGIT_LAST = DIG_W'(NUM_DIGITS - 1);

    logic                  tick;
    logic [DUTY_BITS-1:0]  phase_q;
    logic [DUTY_BITS-1:0]  phase_d;
    logic [DIG_W-1:0]      digit_q;
    logic [DIG_W-1:0]      digit_d;
    logic                  phase_wrap;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_q;
    logic [NUM_DIGITS-1:0] an_d;
    seg_t                  sseg_q;
    seg_t                  sseg_d;
    logic                  frame_q;
    logic                  frame_d;

    tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick_gen (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .o_tick (tick)
    );

    // Phase and digit counters; the digit wrap is explicit so that
    // non-power-of-2 digit counts never reach an unused index.
    always_comb begin
        phase_wrap = tick && (phase_q == '1);
        phase_d    = phase_q;
        digit_d    = digit_q;
        if (tick) begin
            phase_d = phase_q + 1'b1;
        end
        if (phase_wrap) begin
            digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase_q <= '0;
            digit_q <= '0;
        end else begin
            phase_q <= phase_d;
            digit_q <= digit_d;
        end
    end

    // Output stage, evaluated from the pre-update counters so the pins lag
    // the counters by exactly one cycle. Phase 0 stays dark (dead time).
    always_comb begin
        lit = (phase_q != '0) && (phase_q <= bus.i_bright)
              && bus.i_digit_en[digit_q];
        an_d    = '0;
        sseg_d  = SEG_BLANK_N;
        if (lit) begin
            an_d   = AN_LSB << digit_q;
            sseg_d = bus.i_seg_n[digit_q];
        end
        frame_d = phase_wrap && (digit_q == DIGIT_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            an_q    <= '0;
            sseg_q  <= SEG_BLANK_N;
            frame_q <= 1'b0;
        end else begin
            an_q    <= an_d;
            sseg_q  <= sseg_d;
            frame_q <= frame_d;
        end
    end

    assign bus.o_an     = an_q;
    assign bus.o_sseg_n = sseg_q;
    assign bus.o_frame  = frame_q;

endmodule
